serial_spi: RTL and testbench

SERIAL_SPI -- requirements
Module: serial_spi

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_tick_gen.sv | 35 +++
 rtl/serial_spi.sv | 232 +++++++++++++++++++++++
 tb/tb_serial_spi.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and elaboration-time helpers for the serial_spi master.
package serial_pkg;

   // Transfer sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CS_SETUP = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_CS_HOLD  = 2'd3
   } t_spi_state;

   // Main-clock cycles per serial half period, never less than one.
   function automatic int unsigned calc_half(input int unsigned main_hz,
                                             input int unsigned serial_hz);
      int unsigned q;
      q = main_hz / (2 * serial_hz);
      return (q < 1) ? 1 : q;
   endfunction

   // Width of a chip-select index; a single target still gets a 1-bit port.
   function automatic int cs_sel_width(input int num_cs);
      return (num_cs > 1) ? $clog2(num_cs) : 1;
   endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Half-period tick generator: while in_run is high, out_tick fires once every
// HALF cycles; the counter sits at zero whenever in_run is low so the first
// tick of a run always comes exactly HALF cycles after it starts.
module serial_tick_gen
   import serial_pkg::*;
#(
   parameter int HALF = 1
) (
   input  logic in_clk,
   input  logic in_rst,
   input  logic in_run,
   output logic out_tick
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign out_tick  = in_run && w_at_last;

   // Free-running modulo-HALF counter, cleared while not running.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_cnt <= '0;
      end else if (!in_run || w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_spi.sv
// SPI master: word-oriented, configurable mode, bit order and word length,
// with one-hot active-low chip selects and seamless back-to-back bursts.
//
// Handshake: out_ready high means Idle; a cycle with in_enable=1 while Idle
// starts a word using in_parallel/in_cs_sel of that cycle. out_next_word
// pulses at the last leading edge of each word; the user then has until the
// last trailing edge to present the next in_parallel and hold in_enable=1 to
// chain it, or drop in_enable to close the transfer. out_word_finished
// pulses in the cycle out_parallel takes the received word.
module serial_spi
   import serial_pkg::*;
#(
   parameter int   MAIN_CLK_HZ          = 50_000_000,
   parameter int   SERIAL_CLK_HZ        = 1_000_000,
   parameter int   BITS                 = 8,
   parameter logic LOWBIT_FIRST         = 1'b0,
   parameter logic CPOL                 = 1'b0,
   parameter logic CPHA                 = 1'b0,
   parameter int   NUM_CS               = 4,
   parameter logic SERIAL_DATA_INACTIVE = 1'b1
) (
   input  logic                            in_clk,
   input  logic                            in_rst,
   input  logic                            in_enable,
   input  logic [cs_sel_width(NUM_CS)-1:0] in_cs_sel,
   input  logic [BITS-1:0]                 in_parallel,
   output logic                            out_ready,
   output logic                            out_next_word,
   output logic                            out_word_finished,
   output logic [BITS-1:0]                 out_parallel,
   output logic                            out_clk,
   output logic                            out_serial,
   input  logic                            in_serial,
   output logic [NUM_CS-1:0]               out_cs_n,
   output t_spi_state                      out_state
);

   localparam int HALF = int'(calc_half(MAIN_CLK_HZ, SERIAL_CLK_HZ));
   localparam int SW   = cs_sel_width(NUM_CS);
   localparam int EW   = $clog2(2 * BITS);
   // Edge counter values of the final leading and trailing edge of a word.
   localparam logic [EW-1:0] LAST_LEAD = EW'(2 * BITS - 2);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * BITS - 1);

   // Bit that goes on the wire first out of a shift register image.
   function automatic logic head_bit(input logic [BITS-1:0] w);
      return LOWBIT_FIRST ? w[0] : w[BITS-1];
   endfunction

   t_spi_state      r_state;
   t_spi_state      w_state_next;

   logic [BITS-1:0] r_tx;
   logic [BITS-1:0] r_rx;
   logic [BITS-1:0] r_parallel;
   logic [EW-1:0]   r_edge_cnt;
   logic            r_clk;
   logic            r_serial;
   logic [NUM_CS-1:0] r_cs_n;
   logic            r_next_word;
   logic            r_word_fin;

   logic            w_tick;
   logic            w_run;
   logic            w_load;
   logic            w_lead;
   logic            w_trail;
   logic            w_last_lead;
   logic            w_word_end;
   logic            w_hold_done;
   logic [SW-1:0]   w_sel;
   logic [BITS-1:0] w_tx_shifted;
   logic [BITS-1:0] w_rx_next;

   // The tick counter only runs while a transfer is in progress.
   assign w_run = (r_state != ST_IDLE);

   serial_tick_gen #(
      .HALF (HALF)
   ) u_tick_gen (
      .in_clk   (in_clk),
      .in_rst   (in_rst),
      .in_run   (w_run),
      .out_tick (w_tick)
   );

   // Out-of-range targets fall back to chip select 0.
   assign w_sel = (32'(in_cs_sel) >= 32'(NUM_CS)) ? '0 : in_cs_sel;

   // Transmit image after one bit has left, and receive image with the
   // current MISO bit shifted in; both honour the configured bit order.
   assign w_tx_shifted = LOWBIT_FIRST ? (r_tx >> 1) : (r_tx << 1);
   assign w_rx_next    = LOWBIT_FIRST ? {in_serial, r_rx[BITS-1:1]}
                                      : {r_rx[BITS-2:0], in_serial};

   // State register.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and per-cycle edge decode.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_lead       = 1'b0;
      w_trail      = 1'b0;
      w_last_lead  = 1'b0;
      w_word_end   = 1'b0;
      w_hold_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_enable) begin
               w_load       = 1'b1;
               w_state_next = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (w_tick) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               // Even count = odd-numbered tick = leading edge.
               if (!r_edge_cnt[0]) begin
                  w_lead      = 1'b1;
                  w_last_lead = (r_edge_cnt == LAST_LEAD);
               end else begin
                  w_trail = 1'b1;
                  if (r_edge_cnt == LAST_EDGE) begin
                     w_word_end   = 1'b1;
                     w_state_next = in_enable ? ST_SHIFT : ST_CS_HOLD;
                  end
               end
            end
         end
         ST_CS_HOLD: begin
            if (w_tick) begin
               w_hold_done  = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: shift registers, serial clock, chip selects and pulses.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_tx        <= '0;
         r_rx        <= '0;
         r_parallel  <= '0;
         r_edge_cnt  <= '0;
         r_clk       <= CPOL;
         r_serial    <= SERIAL_DATA_INACTIVE;
         r_cs_n      <= '1;
         r_next_word <= 1'b0;
         r_word_fin  <= 1'b0;
      end else begin
         r_next_word <= w_last_lead;
         r_word_fin  <= w_word_end;

         if (w_load) begin
            r_tx       <= in_parallel;
            r_edge_cnt <= '0;
            r_cs_n     <= ~(NUM_CS'(1) << w_sel);
            // Mode 0/2 slaves sample on the first edge, so the first bit
            // must already be on the wire during chip-select setup.
            if (!CPHA) begin
               r_serial <= head_bit(in_parallel);
            end
         end

         if (w_lead) begin
            r_clk      <= ~CPOL;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (CPHA) begin
               r_serial <= head_bit(r_tx);
               r_tx     <= w_tx_shifted;
            end else begin
               r_rx <= w_rx_next;
            end
         end

         if (w_trail) begin
            r_clk <= CPOL;
            if (CPHA) begin
               r_rx <= w_rx_next;
            end
            if (w_word_end) begin
               r_edge_cnt <= '0;
               // In mode 1/3 the final bit is sampled on this very edge.
               r_parallel <= CPHA ? w_rx_next : r_rx;
               if (in_enable) begin
                  r_tx <= in_parallel;
                  if (!CPHA) begin
                     r_serial <= head_bit(in_parallel);
                  end
               end else begin
                  r_serial <= SERIAL_DATA_INACTIVE;
               end
            end else begin
               r_edge_cnt <= r_edge_cnt + 1'b1;
               if (!CPHA) begin
                  r_tx     <= w_tx_shifted;
                  r_serial <= head_bit(w_tx_shifted);
               end
            end
         end

         if (w_hold_done) begin
            r_cs_n <= '1;
         end
      end
   end

   assign out_ready         = (r_state == ST_IDLE);
   assign out_next_word     = r_next_word;
   assign out_word_finished = r_word_fin;
   assign out_parallel      = r_parallel;
   assign out_clk           = r_clk;
   assign out_serial        = r_serial;
   assign out_cs_n          = r_cs_n;
   assign out_state         = r_state;

endmodule

// File: tb/tb_serial_spi.sv
// Directed bench for serial_spi: loopback master (mode 0, MSB first), four
// mode instances against a small slave model, and a 12-bit LSB-first master.
`timescale 1ns/1ps
module tb_serial_spi;
   import serial_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- loopback instance (mode 0, MSB first, 4 CS) ----------------
   logic       lb_en = 1'b0;
   logic [1:0] lb_sel = 2'd0;
   logic [7:0] lb_par = 8'h00;
   logic       lb_ready, lb_nw, lb_wf, lb_sclk, lb_mosi;
   logic [7:0] lb_rx;
   logic [3:0] lb_csn;
   t_spi_state lb_state;

   serial_spi #(
      .MAIN_CLK_HZ(40_000_000), .SERIAL_CLK_HZ(10_000_000), .BITS(8),
      .LOWBIT_FIRST(1'b0), .CPOL(1'b0), .CPHA(1'b0), .NUM_CS(4),
      .SERIAL_DATA_INACTIVE(1'b1)
   ) u_lb (
      .in_clk(clk), .in_rst(rst), .in_enable(lb_en), .in_cs_sel(lb_sel),
      .in_parallel(lb_par), .out_ready(lb_ready), .out_next_word(lb_nw),
      .out_word_finished(lb_wf), .out_parallel(lb_rx), .out_clk(lb_sclk),
      .out_serial(lb_mosi), .in_serial(lb_mosi), .out_cs_n(lb_csn),
      .out_state(lb_state)
   );

   // ---------------- mode 0..3 instances ----------------
   logic       m_en = 1'b0;
   logic [1:0] m_sel = 2'd0;
   logic [7:0] m_par = 8'h00;
   logic       m_ready [4];
   logic       m_nw [4];
   logic       m_wf [4];
   logic       m_clk [4];
   logic       m_mosi [4];
   logic       m_miso [4] = '{default: 1'b1};
   logic [7:0] m_rx [4];
   logic [3:0] m_csn [4];
   t_spi_state m_state [4];

   for (genvar g = 0; g < 4; g++) begin : g_mode
      serial_spi #(
         .MAIN_CLK_HZ(40_000_000), .SERIAL_CLK_HZ(10_000_000), .BITS(8),
         .LOWBIT_FIRST(1'b0), .CPOL(g >= 2), .CPHA((g % 2) == 1), .NUM_CS(4),
         .SERIAL_DATA_INACTIVE(1'b1)
      ) u_dut (
         .in_clk(clk), .in_rst(rst), .in_enable(m_en), .in_cs_sel(m_sel),
         .in_parallel(m_par), .out_ready(m_ready[g]), .out_next_word(m_nw[g]),
         .out_word_finished(m_wf[g]), .out_parallel(m_rx[g]), .out_clk(m_clk[g]),
         .out_serial(m_mosi[g]), .in_serial(m_miso[g]), .out_cs_n(m_csn[g]),
         .out_state(m_state[g])
      );
   end

   // ---------------- 12-bit LSB-first instance, 5 CS ----------------
   logic        x_en = 1'b0;
   logic [2:0]  x_sel = 3'd0;
   logic [11:0] x_par = 12'h000;
   logic        x_ready, x_nw, x_wf, x_sclk, x_mosi;
   logic [11:0] x_rx;
   logic [4:0]  x_csn;
   t_spi_state  x_state;

   serial_spi #(
      .MAIN_CLK_HZ(40_000_000), .SERIAL_CLK_HZ(10_000_000), .BITS(12),
      .LOWBIT_FIRST(1'b1), .CPOL(1'b0), .CPHA(1'b0), .NUM_CS(5),
      .SERIAL_DATA_INACTIVE(1'b1)
   ) u_lsb (
      .in_clk(clk), .in_rst(rst), .in_enable(x_en), .in_cs_sel(x_sel),
      .in_parallel(x_par), .out_ready(x_ready), .out_next_word(x_nw),
      .out_word_finished(x_wf), .out_parallel(x_rx), .out_clk(x_sclk),
      .out_serial(x_mosi), .in_serial(x_mosi), .out_cs_n(x_csn),
      .out_state(x_state)
   );

   // ---------------- slave model / MOSI monitor for the mode instances ----------------
   // MISO carries the inverted bit during the half period where the master
   // must not sample, so sampling on the wrong edge corrupts the word.
   logic [7:0] s_word = 8'hA5;
   logic       s_pclk [4] = '{default: 1'b0};
   logic       s_pmosi [4] = '{default: 1'b1};
   logic       s_pcs [4] = '{default: 1'b1};
   int         s_idx [4] = '{default: 0};
   int         s_edges [4] = '{default: 0};
   logic [7:0] s_cap [4] = '{default: 8'h00};

   always @(negedge clk) begin : p_slave
      logic cpol, cpha, lead;
      for (int m = 0; m < 4; m++) begin
         cpol = (m >= 2);
         cpha = ((m % 2) == 1);
         if (!m_csn[m][0] && s_pcs[m]) begin
            s_idx[m]   = 0;
            s_edges[m] = 0;
            s_cap[m]   = 8'h00;
            if (!cpha) m_miso[m] = s_word[7];
         end else if (m_clk[m] != s_pclk[m]) begin
            lead = (m_clk[m] != cpol);
            if (cpha ? !lead : lead) begin
               s_cap[m]   = {s_cap[m][6:0], s_pmosi[m]};
               s_edges[m] = s_edges[m] + 1;
            end
            if (!cpha) begin
               if (lead) begin
                  m_miso[m] = ~s_word[7 - s_idx[m]];
               end else begin
                  s_idx[m] = s_idx[m] + 1;
                  if (s_idx[m] < 8) m_miso[m] = s_word[7 - s_idx[m]];
               end
            end else begin
               if (lead) begin
                  m_miso[m] = s_word[7 - s_idx[m]];
               end else begin
                  m_miso[m] = ~s_word[7 - s_idx[m]];
                  s_idx[m]  = s_idx[m] + 1;
               end
            end
         end
         s_pclk[m]  = m_clk[m];
         s_pmosi[m] = m_mosi[m];
         s_pcs[m]   = m_csn[m][0];
      end
   end

   // ---------------- scoreboard helper ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver: loopback transfer of 1..3 words ----------------
   task automatic lb_run(input int n, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [1:0] sel,
                         input logic [3:0] exp_csn, input int exp_low);
      logic [7:0] words [3];
      logic [7:0] cap;
      logic       pclk, pmosi;
      int         wfi, nwi, low, last_wf;
      bit         done;
      words = '{w0, w1, w2};
      @(negedge clk);
      lb_en = 1'b1; lb_par = w0; lb_sel = sel;
      cap = 8'h00; pclk = lb_sclk; pmosi = lb_mosi;
      wfi = 0; nwi = 0; low = 0; last_wf = 0; done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(negedge clk);
         if (c == 0) check("lb_csn_at_start", lb_csn, exp_csn);
         if (c == 1) lb_sel = ~sel;   // must be ignored mid-transfer
         if (lb_csn != 4'hF) low++;
         if (lb_sclk && !pclk) cap = {cap[6:0], pmosi};
         pclk = lb_sclk; pmosi = lb_mosi;
         if (lb_nw) begin
            nwi++;
            if (nwi < n) lb_par = words[nwi];
            else lb_en = 1'b0;
         end
         if (lb_wf) begin
            check("lb_rx_word", lb_rx, words[wfi]);
            check("lb_mosi_bits", cap, words[wfi]);
            check("lb_csn_held", lb_csn, exp_csn);
            if (wfi > 0) check("lb_wf_spacing", c - last_wf, 32);
            last_wf = c;
            if (wfi < 2) wfi++;
            else wfi = 3;
         end
         if (lb_ready) done = 1;
      end
      check("lb_done_in_budget", done, 1);
      check("lb_word_count", wfi, n);
      check("lb_cs_low_cycles", low, exp_low);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin : p_main
      int lead, low, nwf;
      int wfc [4];
      logic pclk, pmosi;
      logic [11:0] cap12;
      bit done;

      // Reset state.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", lb_ready, 1);
      check("rst_csn", lb_csn, 4'hF);
      check("rst_sclk", lb_sclk, 0);
      check("rst_mosi", lb_mosi, 1);
      check("rst_rx", lb_rx, 0);
      check("rst_pulses", {lb_nw, lb_wf}, 0);
      check("rst_state", lb_state, ST_IDLE);
      check("rst_cpol1_clk", m_clk[2], 1);
      check("rst_lsb_csn", x_csn, 5'h1F);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", lb_ready, 1);
      check("idle_csn", lb_csn, 4'hF);

      // Single word 0xA5 to CS 2, then a 3-word burst to CS 1, then reset.
      lb_run(1, 8'hA5, 8'h00, 8'h00, 2'd2, 4'b1011, 36);
      lb_run(3, 8'h11, 8'h22, 8'h33, 2'd1, 4'b1101, 100);

      // Reset asserted mid-word after the 4th leading edge.
      @(negedge clk);
      lb_en = 1'b1; lb_par = 8'hA5; lb_sel = 2'd2;
      @(negedge clk);
      lb_en = 1'b0;
      lead = 0; pclk = lb_sclk;
      for (int c = 0; c < 200 && lead < 4; c++) begin
         @(negedge clk);
         if (lb_sclk && !pclk) lead++;
         pclk = lb_sclk;
      end
      check("rst_mid_reached_bit4", lead, 4);
      check("rst_mid_rx_before", lb_rx, 8'h33);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_csn", lb_csn, 4'hF);
      check("rst_mid_sclk", lb_sclk, 0);
      check("rst_mid_ready", lb_ready, 1);
      check("rst_mid_rx", lb_rx, 0);
      check("rst_mid_mosi", lb_mosi, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_state", lb_state, ST_IDLE);

      // Recovery transfer, selected target 3.
      lb_run(1, 8'h5A, 8'h00, 8'h00, 2'd3, 4'b0111, 36);

      // Modes 0..3 against the slave model.
      for (int m = 0; m < 4; m++) begin
         check($sformatf("mode%0d_idle_clk", m), m_clk[m], (m >= 2));
         wfc[m] = 0;
      end
      m_en = 1'b1; m_par = 8'hA5; m_sel = 2'd0;
      @(negedge clk);
      m_en = 1'b0;
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         done = 1;
         for (int m = 0; m < 4; m++) begin
            if (m_wf[m]) wfc[m]++;
            if (!m_ready[m]) done = 0;
         end
      end
      check("mode_done_in_budget", done, 1);
      for (int m = 0; m < 4; m++) begin
         check($sformatf("mode%0d_rx", m), m_rx[m], 8'hA5);
         check($sformatf("mode%0d_mosi_bits", m), s_cap[m], 8'hA5);
         check($sformatf("mode%0d_sample_edges", m), s_edges[m], 8);
         check($sformatf("mode%0d_end_clk", m), m_clk[m], (m >= 2));
         check($sformatf("mode%0d_word_pulses", m), wfc[m], 1);
         check($sformatf("mode%0d_end_mosi", m), m_mosi[m], 1);
      end

      // 12-bit LSB-first word, out-of-range select falls back to CS 0.
      @(negedge clk);
      x_en = 1'b1; x_par = 12'h3C1; x_sel = 3'd7;
      cap12 = 12'h000; pclk = x_sclk; pmosi = x_mosi;
      low = 0; nwf = 0; done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (c == 0) check("lsb_csn_sel7", x_csn, 5'b11110);
         if (x_csn != 5'h1F) low++;
         if (x_sclk && !pclk) cap12 = {pmosi, cap12[11:1]};
         pclk = x_sclk; pmosi = x_mosi;
         if (x_nw) x_en = 1'b0;
         if (x_wf) begin
            nwf++;
            check("lsb_rx", x_rx, 12'h3C1);
            check("lsb_mosi_bits", cap12, 12'h3C1);
         end
         if (x_ready) done = 1;
      end
      check("lsb_done_in_budget", done, 1);
      check("lsb_word_pulses", nwf, 1);
      check("lsb_cs_low_cycles", low, 52);
      check("lsb_rx_hold", x_rx, 12'h3C1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
